answer_check: RTL and testbench

ANSWER_CHECK -- requirements
Module: answer_check

---
 rtl/answer_check_pkg.sv | 35 +++
 rtl/sort3_desc.sv | 35 +++
 rtl/answer_check.sv | 154 +++++++++++++++
 tb/tb_answer_check.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/answer_check_pkg.sv
// ============================================================================
//  Module      : answer_check_pkg
//  Description : Shared types, digit constants and the saturating BCD
//                increment used by the answer checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package answer_check_pkg;

    localparam int c_DIGIT_W    = 4;
    localparam int c_NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_JUDGE = 2'd2,
        S_SHOW  = 2'd3
    } state_t;

    // Two-digit BCD increment that holds at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sort3_desc.sv
// ============================================================================
//  Module      : sort3_desc
//  Description : Combinational three-comparator network ordering three
//                digits largest-first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sort3_desc
    import answer_check_pkg::*;
(
    input  logic [c_DIGIT_W-1:0] i_a,
    input  logic [c_DIGIT_W-1:0] i_b,
    input  logic [c_DIGIT_W-1:0] i_c,
    output logic [c_DIGIT_W-1:0] o_x,
    output logic [c_DIGIT_W-1:0] o_y,
    output logic [c_DIGIT_W-1:0] o_z
);

    logic [c_DIGIT_W-1:0] w_hi1, w_lo1, w_mid2, w_lo2;

    always_comb begin
        // (a,b), then (lo,c), then (hi,mid)
        w_hi1  = (i_a >= i_b) ? i_a : i_b;
        w_lo1  = (i_a >= i_b) ? i_b : i_a;
        w_mid2 = (w_lo1 >= i_c) ? w_lo1 : i_c;
        w_lo2  = (w_lo1 >= i_c) ? i_c : w_lo1;
        o_x    = (w_hi1 >= w_mid2) ? w_hi1 : w_mid2;
        o_y    = (w_hi1 >= w_mid2) ? w_mid2 : w_hi1;
        o_z    = w_lo2;
    end

endmodule

`default_nettype wire

// File: rtl/answer_check.sv
// ============================================================================
//  Module      : answer_check
//  Description : Three-digit answer entry and judgement FSM with BCD score.
//                Define ORDER_FREE_EN to accept any permutation of factors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module answer_check
    import answer_check_pkg::*;
#(
    parameter int SHOW_CYCLES = 25000000,
    parameter int MAX_TRIES   = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] QUESTION,
    input  logic        Q_VALID,
    input  logic [3:0]  KEY_DIGIT,
    input  logic        KEY_VALID,
    input  logic        KEY_CLR,
    output logic [11:0] Q_DISP,
    output logic [11:0] ENTRY,
    output logic        BUSY,
    output logic        CORRECT,
    output logic        WRONG,
    output logic        RESULT_OK,
    output logic        RESULT_NG,
    output logic [7:0]  SCORE
);

    localparam int c_SHOW_W = $clog2(SHOW_CYCLES + 1);
    localparam int c_TRY_W  = $clog2(MAX_TRIES + 1);
    localparam logic [c_SHOW_W-1:0] c_SHOW_LAST = c_SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [c_TRY_W-1:0]  c_MAX_TRIES = c_TRY_W'(MAX_TRIES);
    localparam logic [1:0]          c_LAST_POS  = 2'(c_NUM_DIGITS - 1);

    state_t                r_state;
    logic [23:0]           r_question;
    logic [11:0]           r_entry;
    logic [1:0]            r_count;
    logic [c_TRY_W-1:0]    r_tries;
    logic [c_SHOW_W-1:0]   r_show_cnt;
    logic                  r_correct, r_wrong, r_res_ok, r_res_ng;
    logic [7:0]            r_score;

    logic [c_DIGIT_W-1:0]  w_e0, w_e1, w_e2;
    logic                  w_match;

`ifdef ORDER_FREE_EN
    sort3_desc u_sort3_desc (
        .i_a (r_entry[11:8]),
        .i_b (r_entry[7:4]),
        .i_c (r_entry[3:0]),
        .o_x (w_e0),
        .o_y (w_e1),
        .o_z (w_e2)
    );
`else
    assign w_e0 = r_entry[11:8];
    assign w_e1 = r_entry[7:4];
    assign w_e2 = r_entry[3:0];
`endif

    assign w_match = (w_e0 == r_question[11:8]) &&
                     (w_e1 == r_question[7:4])  &&
                     (w_e2 == r_question[3:0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_question <= '0;
            r_entry    <= '0;
            r_count    <= '0;
            r_tries    <= '0;
            r_show_cnt <= '0;
            r_correct  <= 1'b0;
            r_wrong    <= 1'b0;
            r_res_ok   <= 1'b0;
            r_res_ng   <= 1'b0;
            r_score    <= '0;
        end else begin
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Q_VALID && (QUESTION != 24'd0)) begin
                        r_question <= QUESTION;
                        r_entry    <= '0;
                        r_count    <= '0;
                        r_tries    <= '0;
                        r_state    <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (KEY_CLR) begin
                        r_entry <= '0;
                        r_count <= '0;
                    end else if (KEY_VALID && (KEY_DIGIT <= 4'd9)) begin
                        case (r_count)
                            2'd0:    r_entry[11:8] <= KEY_DIGIT;
                            2'd1:    r_entry[7:4]  <= KEY_DIGIT;
                            default: r_entry[3:0]  <= KEY_DIGIT;
                        endcase
                        r_count <= r_count + 2'd1;
                        if (r_count == c_LAST_POS)
                            r_state <= S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    r_state    <= S_SHOW;
                    r_show_cnt <= c_SHOW_LAST;
                    if (w_match) begin
                        r_correct <= 1'b1;
                        r_res_ok  <= 1'b1;
                        r_score   <= bcd_inc_sat(r_score);
                    end else begin
                        r_wrong  <= 1'b1;
                        r_res_ng <= 1'b1;
                        r_tries  <= r_tries + 1'b1;
                    end
                end
                default: begin
                    if (r_show_cnt == '0) begin
                        r_res_ok <= 1'b0;
                        r_res_ng <= 1'b0;
                        if (r_res_ok || (r_tries == c_MAX_TRIES)) begin
                            r_state <= S_IDLE;
                        end else begin
                            // Retry: the player starts the triple over.
                            r_state <= S_ENTRY;
                            r_entry <= '0;
                            r_count <= '0;
                        end
                    end else begin
                        r_show_cnt <= r_show_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign Q_DISP    = r_question[23:12];
    assign ENTRY     = r_entry;
    assign BUSY      = (r_state != S_IDLE);
    assign CORRECT   = r_correct;
    assign WRONG     = r_wrong;
    assign RESULT_OK = r_res_ok;
    assign RESULT_NG = r_res_ng;
    assign SCORE     = r_score;

endmodule

`default_nettype wire

// File: tb/tb_answer_check.sv
// ============================================================================
//  Module      : tb_answer_check
//  Description : Scoreboard bench for answer_check (SHOW_CYCLES=4, MAX_TRIES=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_answer_check;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [23:0] QUESTION = '0;
    logic        Q_VALID = 1'b0;
    logic [3:0]  KEY_DIGIT = '0;
    logic        KEY_VALID = 1'b0;
    logic        KEY_CLR = 1'b0;
    logic [11:0] Q_DISP, ENTRY;
    logic        BUSY, CORRECT, WRONG, RESULT_OK, RESULT_NG;
    logic [7:0]  SCORE;

    answer_check #(.SHOW_CYCLES(4), .MAX_TRIES(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .QUESTION  (QUESTION),
        .Q_VALID   (Q_VALID),
        .KEY_DIGIT (KEY_DIGIT),
        .KEY_VALID (KEY_VALID),
        .KEY_CLR   (KEY_CLR),
        .Q_DISP    (Q_DISP),
        .ENTRY     (ENTRY),
        .BUSY      (BUSY),
        .CORRECT   (CORRECT),
        .WRONG     (WRONG),
        .RESULT_OK (RESULT_OK),
        .RESULT_NG (RESULT_NG),
        .SCORE     (SCORE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ok;
        logic [7:0] score;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_ok  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_score(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // Judgement pulses are matched against the queued expectations.
    always @(negedge CLK) begin
        if (!RST && (CORRECT || WRONG)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_judge", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_verdict", 32'({CORRECT, WRONG}), e.ok ? 32'd2 : 32'd1);
                chk("sb_score", 32'(SCORE), 32'(e.score));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [23:0] q);
        QUESTION = q;
        Q_VALID  = 1'b1;
        tick();
        Q_VALID  = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        KEY_DIGIT = d;
        KEY_VALID = 1'b1;
        tick();
        KEY_VALID = 1'b0;
    endtask

    task automatic answer(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic ok);
        int cnt;
        if (ok) n_ok++;
        exp_q.push_back('{ok: ok, score: exp_score(n_ok)});
        key(d0);
        key(d1);
        key(d2);
        chk("judge_latency", 32'({CORRECT, WRONG}), 32'd0);
        tick();
        chk("pulse", 32'({CORRECT, WRONG}), ok ? 32'd2 : 32'd1);
        chk("level", 32'({RESULT_OK, RESULT_NG}), ok ? 32'd2 : 32'd1);
        cnt = 0;
        while ((RESULT_OK || RESULT_NG) && cnt < 20) begin
            cnt++;
            tick();
            if (cnt == 1) chk("pulse_width", 32'({CORRECT, WRONG}), 32'd0);
        end
        chk("show_len", 32'(cnt), 32'd4);
    endtask

    initial begin
        repeat (3) tick();
        RST = 1'b0;
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_score", 32'(SCORE), 0);
        chk("rst_qdisp", 32'(Q_DISP), 0);
        chk("rst_entry", 32'(ENTRY), 0);
        chk("rst_levels", 32'({CORRECT, WRONG, RESULT_OK, RESULT_NG}), 0);

        // Positional match
        load(24'h027222);
        chk("q_disp", 32'(Q_DISP), 'h027);
        chk("busy_entry", 32'(BUSY), 1);
        answer(4'd2, 4'd2, 4'd2, 1'b1);
        chk("idle_after_ok", 32'(BUSY), 0);
        chk("score_1", 32'(SCORE), 'h01);

        // Permuted entry
        load(24'h042421);
`ifdef ORDER_FREE_EN
        answer(4'd1, 4'd2, 4'd4, 1'b1);
        chk("perm_idle", 32'(BUSY), 0);
        load(24'h042421);
`else
        answer(4'd1, 4'd2, 4'd4, 1'b0);
        chk("perm_retry_busy", 32'(BUSY), 1);
        chk("perm_retry_entry", 32'(ENTRY), 0);
`endif
        answer(4'd4, 4'd2, 4'd1, 1'b1);
        chk("perm_score", 32'(SCORE), 32'(exp_score(n_ok)));

        // Exhausted tries
        load(24'h030321);
        answer(4'd1, 4'd1, 4'd1, 1'b0);
        chk("try1_busy", 32'(BUSY), 1);
        chk("try1_entry", 32'(ENTRY), 0);
        answer(4'd5, 4'd5, 4'd5, 1'b0);
        answer(4'd0, 4'd0, 4'd0, 1'b0);
        chk("tries_idle", 32'(BUSY), 0);
        chk("tries_score", 32'(SCORE), 32'(exp_score(n_ok)));

        // Clear priority, ignored digit, ignored reload
        load(24'h195632);
        key(4'd6);
        key(4'd3);
        chk("partial_entry", 32'(ENTRY), 'h630);
        KEY_CLR   = 1'b1;
        KEY_DIGIT = 4'd9;
        KEY_VALID = 1'b1;
        tick();
        KEY_CLR   = 1'b0;
        KEY_VALID = 1'b0;
        chk("clr_entry", 32'(ENTRY), 'h000);
        key(4'hA);
        chk("digit_a_ignored", 32'(ENTRY), 'h000);
        load(24'h111111);
        chk("reload_ignored", 32'(Q_DISP), 'h195);
        answer(4'd6, 4'd3, 4'd2, 1'b1);

        // Score saturation
        while (n_ok < 100) begin
            load(24'h027222);
            answer(4'd2, 4'd2, 4'd2, 1'b1);
        end
        chk("score_sat", 32'(SCORE), 'h99);
        load(24'h000000);
        chk("zero_q_ignored", 32'(BUSY), 0);

        // Reset mid-entry
        load(24'h027222);
        key(4'd2);
        key(4'd2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_ok = 0;
        chk("rst_mid_busy", 32'(BUSY), 0);
        chk("rst_mid_entry", 32'(ENTRY), 0);
        chk("rst_mid_qdisp", 32'(Q_DISP), 0);
        chk("rst_mid_score", 32'(SCORE), 0);

        // Reset mid-show
        load(24'h027222);
        n_ok++;
        exp_q.push_back('{ok: 1'b1, score: exp_score(n_ok)});
        key(4'd2);
        key(4'd2);
        key(4'd2);
        tick();
        chk("pre_rst_ok", 32'(RESULT_OK), 1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_ok = 0;
        chk("rst_show_busy", 32'(BUSY), 0);
        chk("rst_show_levels", 32'({CORRECT, WRONG, RESULT_OK, RESULT_NG}), 0);
        chk("rst_show_score", 32'(SCORE), 0);
        chk("rst_show_qdisp", 32'(Q_DISP), 0);
        repeat (6) tick();
        chk("rst_show_stays_idle", 32'(BUSY), 0);
        chk("sb_drain", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
